// File: rtl/traffic_phase_monitor_if.sv
// traffic_phase_monitor_if: lamp/duration inputs and status outputs of the phase monitor
//   master: lamp driver side (controller or bench); slave: the monitor.
//   Signals: *_led, night_mode, *_ticks and clear_err toward the monitor;
//   err_flag, err_code, phase, phase_sec and cycle_count back from it.
//   MON_LAST_DUR_EN adds last_dur/last_phase.
interface traffic_phase_monitor_if #(
    parameter int CNT_W = 32
);
    logic             green_led;
    logic             yellow_led;
    logic             red_led;
    logic             walk_led;
    logic             dont_walk_led;
    logic             night_mode;
    logic [CNT_W-1:0] green_ticks;
    logic [CNT_W-1:0] yellow_ticks;
    logic [CNT_W-1:0] red_ticks;
    logic             clear_err;
    logic             err_flag;
    logic [2:0]       err_code;
    logic [1:0]       phase;
    logic [3:0]       phase_sec;
    logic [7:0]       cycle_count;
`ifdef MON_LAST_DUR_EN
    logic [CNT_W-1:0] last_dur;
    logic [1:0]       last_phase;
    modport master (
        output green_led, yellow_led, red_led, walk_led, dont_walk_led, night_mode,
        output green_ticks, yellow_ticks, red_ticks, clear_err,
        input  err_flag, err_code, phase, phase_sec, cycle_count, last_dur, last_phase
    );
    modport slave (
        input  green_led, yellow_led, red_led, walk_led, dont_walk_led, night_mode,
        input  green_ticks, yellow_ticks, red_ticks, clear_err,
        output err_flag, err_code, phase, phase_sec, cycle_count, last_dur, last_phase
    );
`else
    modport master (
        output green_led, yellow_led, red_led, walk_led, dont_walk_led, night_mode,
        output green_ticks, yellow_ticks, red_ticks, clear_err,
        input  err_flag, err_code, phase, phase_sec, cycle_count
    );
    modport slave (
        input  green_led, yellow_led, red_led, walk_led, dont_walk_led, night_mode,
        input  green_ticks, yellow_ticks, red_ticks, clear_err,
        output err_flag, err_code, phase, phase_sec, cycle_count
    );
`endif
endinterface

// File: rtl/traffic_phase_monitor.sv
// traffic_phase_monitor: checks observed lamp phases for sequence, legality and timing
//   clk, reset_n (async, active-low) plus bus (traffic_phase_monitor_if.slave).
//   bus inputs : green/yellow/red/walk/dont_walk lamps, night_mode, programmed
//                green/yellow/red lengths, clear_err.
//   bus outputs: sticky err_flag/err_code (1 LAMP,2 WALK,3 PED,4 SEQ,5 TIME,6 STUCK),
//                phase (0 idle/night,1 G,2 Y,3 R), phase_sec, cycle_count.
//   Optional MON_LAST_DUR_EN: last_dur/last_phase of the last completed phase.
module traffic_phase_monitor #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TOL_TICKS     = 1000,
    parameter int STUCK_TICKS   = 25_000_000,
    parameter int CNT_W         = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    traffic_phase_monitor_if.slave bus
);
    typedef enum logic [2:0] {MON_IDLE, MON_GREEN, MON_YELLOW, MON_RED, MON_NIGHT} state_t;
    localparam logic [CNT_W:0] TOL_X    = (CNT_W+1)'(TOL_TICKS);
    localparam logic [CNT_W:0] STUCK_X  = (CNT_W+1)'(STUCK_TICKS);
    localparam logic [31:0]    TICK_MAX = 32'(TICKS_PER_SEC - 1);
    state_t           state_q, state_d, lamp_st;
    logic             g_q, y_q, r_q, w_q, dw_q, nm_q;
    logic             first_q, first_d, err_flag_q, err_flag_d;
    logic [2:0]       err_code_q, err_code_d, err_new;
    logic [CNT_W-1:0] cnt_q, cnt_d, prog;
    logic [31:0]      tick_q, tick_d;
    logic [3:0]       sec_q, sec_d;
    logic [7:0]       cyc_q, cyc_d;
    logic [CNT_W:0]   cnt_x, prog_x, lo_x;
    logic [1:0]       phase_c;
    logic             one_lit, in_ph, in_ph_d, enter, change, legal, latch;
    logic             lamp_bad, walk_bad, ped_bad, seq_bad, time_bad, stuck_bad;
    assign one_lit = $onehot({g_q, y_q, r_q});
    assign lamp_st = g_q ? MON_GREEN : (y_q ? MON_YELLOW : MON_RED);
    assign in_ph   = state_q inside {MON_GREEN, MON_YELLOW, MON_RED};
    assign phase_c = state_q == MON_GREEN ? 2'd1 : state_q == MON_YELLOW ? 2'd2 : state_q == MON_RED ? 2'd3 : 2'd0;
    always_comb begin
        state_d   = nm_q ? MON_NIGHT : ((one_lit && lamp_st != state_q) ? lamp_st : state_q);
        in_ph_d   = state_d inside {MON_GREEN, MON_YELLOW, MON_RED};
        enter     = in_ph_d && state_d != state_q;
        change    = enter && in_ph;
        legal     = (state_q == MON_GREEN && state_d == MON_YELLOW) ||
                    (state_q == MON_YELLOW && state_d == MON_RED) ||
                    (state_q == MON_RED && state_d == MON_GREEN);
        prog      = state_q == MON_GREEN ? bus.green_ticks : (state_q == MON_YELLOW ? bus.yellow_ticks : bus.red_ticks);
        cnt_x     = {1'b0, cnt_q};
        prog_x    = {1'b0, prog};
        // lower bound clamps at 0 instead of wrapping
        lo_x      = prog_x > TOL_X ? prog_x - TOL_X : '0;
        // dark lamps are only an error once a phase is being tracked
        lamp_bad  = nm_q ? (g_q | r_q) : (!one_lit && (in_ph || g_q || y_q || r_q));
        walk_bad  = !nm_q && w_q && !r_q;
        ped_bad   = w_q && dw_q;
        seq_bad   = change && !legal;
        // red has only a minimum length; the first (partial) phase is not timed
        time_bad  = change && !first_q && (cnt_x < lo_x || (state_q != MON_RED && cnt_x > prog_x + TOL_X));
        stuck_bad = !nm_q && in_ph && cnt_x > prog_x + STUCK_X;
        err_new   = lamp_bad ? 3'd1 : walk_bad ? 3'd2 : ped_bad ? 3'd3 :
                    seq_bad ? 3'd4 : time_bad ? 3'd5 : stuck_bad ? 3'd6 : 3'd0;
        latch      = err_new != 3'd0 && (!err_flag_q || bus.clear_err);
        err_flag_d = latch ? 1'b1 : (bus.clear_err ? 1'b0 : err_flag_q);
        err_code_d = latch ? err_new : (bus.clear_err ? 3'd0 : err_code_q);
        first_d    = enter ? !in_ph : first_q;
        cnt_d      = !in_ph_d ? '0 : enter ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        tick_d     = (!in_ph_d || enter || tick_q == TICK_MAX) ? '0 : tick_q + 32'd1;
        sec_d      = (!in_ph_d || enter) ? 4'd0 : ((tick_q == TICK_MAX && sec_q != 4'd15) ? sec_q + 4'd1 : sec_q);
        cyc_d      = (state_q == MON_RED && state_d == MON_GREEN) ? cyc_q + 8'd1 : cyc_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {g_q, y_q, r_q, w_q, dw_q, nm_q} <= '0;
            state_q    <= MON_IDLE;
            first_q    <= 1'b0;
            err_flag_q <= 1'b0;
            err_code_q <= '0;
            cnt_q      <= '0;
            tick_q     <= '0;
            sec_q      <= '0;
            cyc_q      <= '0;
        end else begin
            {g_q, y_q, r_q, w_q, dw_q, nm_q} <= {bus.green_led, bus.yellow_led, bus.red_led,
                                                 bus.walk_led, bus.dont_walk_led, bus.night_mode};
            state_q    <= state_d;
            first_q    <= first_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            cyc_q      <= cyc_d;
        end
    end
    assign bus.err_flag    = err_flag_q;
    assign bus.err_code    = err_code_q;
    assign bus.phase       = phase_c;
    assign bus.phase_sec   = sec_q;
    assign bus.cycle_count = cyc_q;
`ifdef MON_LAST_DUR_EN
    logic [CNT_W-1:0] last_dur_q;
    logic [1:0]       last_phase_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dur_q   <= '0;
            last_phase_q <= '0;
        end else if (in_ph && state_d != state_q) begin
            last_dur_q   <= cnt_q;
            last_phase_q <= phase_c;
        end
    end
    assign bus.last_dur   = last_dur_q;
    assign bus.last_phase = last_phase_q;
`endif
endmodule

// File: tb/tb_traffic_phase_monitor.sv
// tb_traffic_phase_monitor: directed scenarios plus random lamp traffic against a reference model
module tb_traffic_phase_monitor;
    localparam int TPS = 10;
    localparam int TOL = 2;
    localparam int STK = 20;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    traffic_phase_monitor_if #(.CNT_W(32)) bus ();
    traffic_phase_monitor #(.TICKS_PER_SEC(TPS), .TOL_TICKS(TOL), .STUCK_TICKS(STK), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct packed { bit g; bit y; bit r; bit w; bit dw; bit nm; } samp_t;
    typedef struct packed { int ph; int len; bit first; bit flag; int code; int cyc; } mod_t;
    samp_t s;
    mod_t  m;
    int    esec;
    logic [17:0] exp_v, dut_v;
    // ph: 0 idle, 1 green, 2 yellow, 3 red, 4 night; len = cycles spent in the phase so far
    function automatic mod_t mnext(mod_t c, samp_t x, bit clr, int gt, int yt, int rt);
        mod_t   n = c;
        int     nlit, lp, prog, e, np;
        bit     inph, chg;
        longint diff;
        nlit = int'(x.g) + int'(x.y) + int'(x.r);
        lp   = x.g ? 1 : (x.y ? 2 : 3);
        inph = c.ph >= 1 && c.ph <= 3;
        prog = c.ph == 1 ? gt : (c.ph == 2 ? yt : rt);
        chg  = !x.nm && inph && nlit == 1 && lp != c.ph;
        diff = longint'(c.len) - longint'(prog);
        e = 0;
        if (x.nm ? (x.g || x.r) : (nlit > 1 || (inph && nlit == 0))) e = 1;
        else if (!x.nm && x.w && !x.r) e = 2;
        else if (x.w && x.dw) e = 3;
        else if (chg && lp != c.ph % 3 + 1) e = 4;
        else if (chg && !c.first && (c.ph == 3 ? diff < -TOL : (diff > TOL || diff < -TOL))) e = 5;
        else if (!x.nm && inph && diff > STK) e = 6;
        if (e != 0 && (!c.flag || clr)) begin
            n.flag = 1'b1;
            n.code = e;
        end else if (clr) begin
            n.flag = 1'b0;
            n.code = 0;
        end
        np = x.nm ? 4 : (nlit == 1 ? lp : c.ph);
        if (np != c.ph) begin
            if (c.ph == 3 && np == 1) n.cyc = (c.cyc + 1) % 256;
            n.len   = (np >= 1 && np <= 3) ? 1 : 0;
            n.first = !inph;
            n.ph    = np;
        end else if (inph) begin
            n.len = c.len + 1;
        end
        return n;
    endfunction
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
            s <= '0;
        end else begin
            m <= mnext(m, s, bus.clear_err, int'(bus.green_ticks), int'(bus.yellow_ticks), int'(bus.red_ticks));
            s <= {bus.green_led, bus.yellow_led, bus.red_led, bus.walk_led, bus.dont_walk_led, bus.night_mode};
        end
    end
    always_comb begin
        esec = (m.ph >= 1 && m.ph <= 3) ? (m.len - 1) / TPS : 0;
        if (esec > 15) esec = 15;
        exp_v = {m.flag, 3'(m.code), (m.ph >= 1 && m.ph <= 3) ? 2'(m.ph) : 2'd0, 4'(esec), 8'(m.cyc)};
    end
    assign dut_v = {bus.err_flag, bus.err_code, bus.phase, bus.phase_sec, bus.cycle_count};
    task automatic drive(input bit g, input bit y, input bit r, input bit w, input bit dw, input bit nm);
        bus.green_led     = g;
        bus.yellow_led    = y;
        bus.red_led       = r;
        bus.walk_led      = w;
        bus.dont_walk_led = dw;
        bus.night_mode    = nm;
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_ticks(input int gt, input int yt, input int rt);
        bus.green_ticks  = 32'(gt);
        bus.yellow_ticks = 32'(yt);
        bus.red_ticks    = 32'(rt);
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 1, 0);
        bus.clear_err = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
    endtask
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_v !== 18'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", dut_v); end
        cycles(3);
        checks++;
        if (dut_v !== 18'd0) begin errors++; $display("FAIL reset_idle_dark: got %h expected 0", dut_v); end
    endtask
    task automatic test_normal_cycle();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(50);
        drive(0, 1, 0, 0, 1, 0); cycles(30);
        drive(0, 0, 1, 1, 0, 0); cycles(40);
        drive(1, 0, 0, 0, 1, 0); cycles(46);
        checks++;
        if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL normal_err: got %0d expected 0", bus.err_flag); end
        checks++;
        if (bus.cycle_count !== 8'd1) begin errors++; $display("FAIL normal_cycles: got %0d expected 1", bus.cycle_count); end
        checks++;
        if (bus.phase_sec !== 4'd4 || bus.phase !== 2'd1) begin
            errors++; $display("FAIL normal_sec: got sec %0d phase %0d expected 4 1", bus.phase_sec, bus.phase);
        end
        checks++;
        if (dut_v !== exp_v) begin errors++; $display("FAIL normal_model: got %h expected %h", dut_v, exp_v); end
    endtask
    task automatic test_seq();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(50);
        drive(0, 0, 1, 0, 1, 0); cycles(1);
        checks++;
        if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL seq_latency: got %0d expected 0", bus.err_flag); end
        cycles(1);
        checks++;
        if (bus.err_flag !== 1'b1 || bus.err_code !== 3'd4) begin
            errors++; $display("FAIL seq_code: got %0d/%0d expected 1/4", bus.err_flag, bus.err_code);
        end
        drive(0, 1, 0, 0, 1, 0); cycles(5);
        checks++;
        if (bus.err_code !== 3'd4) begin errors++; $display("FAIL seq_sticky: got %0d expected 4", bus.err_code); end
    endtask
    task automatic test_lamp_clear();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(10);
        drive(1, 0, 1, 0, 1, 0); cycles(2);
        checks++;
        if (bus.err_code !== 3'd1) begin errors++; $display("FAIL lamp_code: got %0d expected 1", bus.err_code); end
        drive(1, 0, 0, 1, 0, 0); cycles(1);
        bus.clear_err = 1'b1; cycles(1); bus.clear_err = 1'b0;
        checks++;
        if (bus.err_flag !== 1'b1 || bus.err_code !== 3'd2) begin
            errors++; $display("FAIL clear_with_new: got %0d/%0d expected 1/2", bus.err_flag, bus.err_code);
        end
        drive(1, 0, 0, 0, 1, 0); cycles(2);
        bus.clear_err = 1'b1; cycles(1); bus.clear_err = 1'b0;
        checks++;
        if (bus.err_flag !== 1'b0 || bus.err_code !== 3'd0) begin
            errors++; $display("FAIL clear_plain: got %0d/%0d expected 0/0", bus.err_flag, bus.err_code);
        end
    endtask
    task automatic test_walk_ped();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(5);
        drive(1, 0, 0, 1, 0, 0); cycles(2);
        checks++;
        if (bus.err_code !== 3'd2) begin errors++; $display("FAIL walk_code: got %0d expected 2", bus.err_code); end
        drive(1, 0, 0, 0, 1, 0); cycles(2);
        bus.clear_err = 1'b1; cycles(1); bus.clear_err = 1'b0;
        checks++;
        if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL walk_clear: got %0d expected 0", bus.err_flag); end
        drive(0, 0, 1, 1, 1, 0); cycles(2);
        checks++;
        if (bus.err_code !== 3'd3) begin errors++; $display("FAIL ped_code: got %0d expected 3", bus.err_code); end
    endtask
    task automatic test_time();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(10);
        drive(0, 1, 0, 0, 1, 0); cycles(30);
        drive(0, 0, 1, 0, 1, 0); cycles(40);
        drive(1, 0, 0, 0, 1, 0); cycles(55);
        checks++;
        if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL time_pre: got %0d expected 0", bus.err_flag); end
        drive(0, 1, 0, 0, 1, 0); cycles(2);
        checks++;
        if (bus.err_code !== 3'd5) begin errors++; $display("FAIL time_code: got %0d expected 5", bus.err_code); end
    endtask
    task automatic test_stuck();
        set_ticks(50, 30, 40);
        do_reset();
        drive(1, 0, 0, 0, 1, 0); cycles(72);
        checks++;
        if (bus.err_flag !== 1'b0) begin errors++; $display("FAIL stuck_pre: got %0d expected 0", bus.err_flag); end
        cycles(1);
        checks++;
        if (bus.err_code !== 3'd6) begin errors++; $display("FAIL stuck_code: got %0d expected 6", bus.err_code); end
    endtask
    task automatic test_night();
        set_ticks(50, 30, 40);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, bit'(i % 2), 0, 0, 1, 1);
            cycles(5);
        end
        checks++;
        if (bus.err_flag !== 1'b0 || bus.phase !== 2'd0) begin
            errors++; $display("FAIL night_quiet: got flag %0d phase %0d expected 0 0", bus.err_flag, bus.phase);
        end
        drive(0, 0, 1, 0, 1, 1); cycles(2);
        checks++;
        if (bus.err_code !== 3'd1) begin errors++; $display("FAIL night_lamp: got %0d expected 1", bus.err_code); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== 18'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", dut_v); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    task automatic test_random();
        int gt, yt, rt, cur, len, kind;
        bit [2:0] lamps;
        bit w, dw, nm;
        gt = int'($urandom_range(8, 20));
        yt = int'($urandom_range(5, 12));
        rt = int'($urandom_range(8, 20));
        set_ticks(gt, yt, rt);
        do_reset();
        cur = 2;
        for (int seg = 0; seg < 80; seg++) begin
            kind = int'($urandom_range(0, 19));
            w = 1'b0; dw = 1'b1; nm = 1'b0;
            cur = (kind == 3) ? (cur + 2) % 3 : (cur + 1) % 3;
            lamps = cur == 0 ? 3'b100 : (cur == 1 ? 3'b010 : 3'b001);
            len = (cur == 0 ? gt : (cur == 1 ? yt : rt)) + int'($urandom_range(0, 8)) - 4;
            if (kind == 4) len += 25;
            if (kind == 0) begin nm = 1'b1; lamps = 3'b010; end
            if (kind == 1) lamps = 3'($urandom_range(0, 7));
            if (cur == 2 && kind > 10) begin w = 1'b1; dw = 1'b0; end
            if (kind == 2) w = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (nm && i % 4 == 0) lamps[1] = ~lamps[1];
                drive(lamps[2], lamps[1], lamps[0], w, dw, nm);
                bus.clear_err = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                checks++;
                if (dut_v !== exp_v) begin
                    errors++; $display("FAIL random seg %0d cyc %0d: got %h expected %h", seg, i, dut_v, exp_v);
                end
            end
        end
        bus.clear_err = 1'b0;
    endtask
    initial begin
        set_ticks(50, 30, 40);
        test_reset();
        test_normal_cycle();
        test_seq();
        test_lamp_clear();
        test_walk_ped();
        test_time();
        test_stuck();
        test_night();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
